// File: rtl/urcpu_pkg.sv
// Shared CPU-side constants: datapath width, arbiter states and requester ids.
package urcpu_pkg;

   localparam int unsigned DATA_W = 20;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int unsigned PC   = 0;
   localparam int unsigned SP   = 1;
   localparam int unsigned LOOP = 2;
   localparam int unsigned DMA  = 3;

endpackage

// File: rtl/increment_module.sv
// Shared WIDTH-bit incrementer; the result wraps modulo 2^WIDTH.
module increment_module #(
   parameter int unsigned WIDTH = 20
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] out
);

   assign out = a + WIDTH'(1);

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id
);

   logic [ID_W-1:0] idx;
   logic            found;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = ID_W'((32'(ptr) + i) % NUM_REQ);
         if (!found && valid[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = idx;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/incr_arbiter.sv
// Round-robin time-sharing of one incrementer among NUM_REQ requesters,
// with a held response carrying the requester id and a wrap flag.
module incr_arbiter
   import urcpu_pkg::*;
#(
   parameter int unsigned WIDTH   = DATA_W,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     rsp_wrap,
   input  logic                     rsp_ready,
   output logic                     busy
);

   state_t             state;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    cur_id;
   logic [WIDTH-1:0]   op;
   logic [WIDTH-1:0]   op_sel;
   logic [WIDTH-1:0]   inc_out;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic [ID_W-1:0]    ptr_next;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .valid    (req_valid),
      .ptr      (rr_ptr),
      .grant    (grant),
      .grant_id (grant_id)
   );

   increment_module #(
      .WIDTH (WIDTH)
   ) u_inc (
      .a   (op),
      .out (inc_out)
   );

   // Suppress grants in a reset cycle so no requester sees a handshake that is discarded.
   assign req_ready = (state == IDLE && !rst) ? grant : '0;

   assign ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

   always_comb begin
      op_sel = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (grant_id == ID_W'(k)) op_sel = req_data[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_id    <= '0;
         op        <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_wrap  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|req_valid) begin
                  op     <= op_sel;
                  cur_id <= grant_id;
                  rr_ptr <= ptr_next;
                  state  <= CALC;
                  busy   <= 1'b1;
               end
            end
            CALC: begin
               rsp_data  <= inc_out;
               rsp_wrap  <= &op;
               rsp_id    <= cur_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
                  busy      <= 1'b0;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_incr_arbiter.sv
// Directed and scoreboarded random checks of incr_arbiter.
module tb_incr_arbiter;
   import urcpu_pkg::*;

   localparam int unsigned WIDTH   = 20;
   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ID_W    = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     rsp_valid;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_data;
   logic                     rsp_wrap;
   logic                     rsp_ready;
   logic                     busy;

   int n_cmp = 0;
   int n_err = 0;

   incr_arbiter #(
      .WIDTH   (WIDTH),
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_wrap  (rsp_wrap),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_data(input int k, input logic [WIDTH-1:0] d);
      req_data[k*WIDTH +: WIDTH] = d;
   endtask

   logic [WIDTH-1:0] ops [NUM_REQ];
   logic [WIDTH-1:0] cur_data [NUM_REQ];
   int               wait_cnt [NUM_REQ];
   logic [NUM_REQ-1:0] gnt_seen;
   logic [WIDTH-1:0] exp_data;
   logic [ID_W-1:0]  exp_id;
   int               g;
   int               n_done;
   int unsigned      seed;

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b0;
      step();
      step();
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_rsp_id", 32'(rsp_id), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      check("rst_rsp_wrap", 32'(rsp_wrap), 0);
      check("rst_req_ready", 32'(req_ready), 0);

      // Single request from PC
      rst = 1'b0;
      set_data(PC, 20'h00010);
      req_valid = 4'b0001;
      #1 check("t1_ready", 32'(req_ready), 32'h1);
      step();
      req_valid = '0;
      #1;
      check("t1_calc_busy", 32'(busy), 1);
      check("t1_calc_rsp_valid", 32'(rsp_valid), 0);
      check("t1_calc_ready", 32'(req_ready), 0);
      step();
      #1;
      check("t1_rsp_valid", 32'(rsp_valid), 1);
      check("t1_rsp_id", 32'(rsp_id), PC);
      check("t1_rsp_data", 32'(rsp_data), 32'h00011);
      check("t1_rsp_wrap", 32'(rsp_wrap), 0);
      rsp_ready = 1'b1;
      step();
      #1;
      check("t1_done_valid", 32'(rsp_valid), 0);
      check("t1_done_busy", 32'(busy), 0);

      // Wrap case on LOOP
      set_data(LOOP, 20'hFFFFF);
      req_valid = 4'b0100;
      #1 check("t2_ready", 32'(req_ready), 32'h4);
      step();
      req_valid = '0;
      step();
      #1;
      check("t2_rsp_valid", 32'(rsp_valid), 1);
      check("t2_rsp_data", 32'(rsp_data), 0);
      check("t2_rsp_wrap", 32'(rsp_wrap), 1);
      check("t2_rsp_id", 32'(rsp_id), LOOP);
      step();

      // Round-robin with all requesters held valid, from a fresh pointer
      rst = 1'b1;
      step();
      rst = 1'b0;
      ops[0] = 20'h0ABCD;
      ops[1] = 20'h12345;
      ops[2] = 20'h7FFFF;
      ops[3] = 20'hFFFFE;
      for (int k = 0; k < NUM_REQ; k++) set_data(k, ops[k]);
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         g = n % NUM_REQ;
         #1 check("rr_grant", 32'(req_ready), 32'(1) << g);
         step();
         #1 check("rr_calc_ready", 32'(req_ready), 0);
         step();
         #1;
         check("rr_rsp_id", 32'(rsp_id), 32'(g));
         check("rr_rsp_data", 32'(rsp_data), 32'(ops[g] + 20'd1));
         check("rr_rsp_wrap", 32'(rsp_wrap), 0);
         step();
      end

      // Back-pressure: response held while SP waits
      rsp_ready = 1'b0;
      set_data(PC, 20'h00100);
      req_valid = 4'b0001;
      #1 check("bp_grant0", 32'(req_ready), 32'h1);
      step();
      set_data(SP, 20'h55555);
      req_valid = 4'b0010;
      #1 check("bp_calc_ready", 32'(req_ready), 0);
      step();
      for (int n = 0; n < 5; n++) begin
         #1;
         check("bp_hold_valid", 32'(rsp_valid), 1);
         check("bp_hold_data", 32'(rsp_data), 32'h00101);
         check("bp_hold_id", 32'(rsp_id), PC);
         check("bp_hold_ready", 32'(req_ready), 0);
         step();
      end
      rsp_ready = 1'b1;
      #1 check("bp_release_data", 32'(rsp_data), 32'h00101);
      step();
      #1 check("bp_grant1", 32'(req_ready), 32'h2);
      step();
      req_valid = '0;
      step();
      #1;
      check("bp_sp_id", 32'(rsp_id), SP);
      check("bp_sp_data", 32'(rsp_data), 32'h55556);
      step();

      // Reset during CALC aborts the DMA operation
      set_data(DMA, 20'h00ABC);
      req_valid = 4'b1000;
      #1 check("ab_grant3", 32'(req_ready), 32'h8);
      step();
      req_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("ab_rsp_valid", 32'(rsp_valid), 0);
      check("ab_busy", 32'(busy), 0);
      for (int n = 0; n < 4; n++) begin
         step();
         #1 check("ab_no_rsp", 32'(rsp_valid), 0);
      end
      for (int k = 0; k < NUM_REQ; k++) set_data(k, ops[k]);
      req_valid = 4'hF;
      #1 check("ab_ptr_zero", 32'(req_ready), 32'h1);
      step();
      req_valid = '0;
      step();
      #1 check("ab_next_id", 32'(rsp_id), 0);
      step();

      // Random requests with scoreboard and starvation bound
      seed = 48377;
      void'($urandom(seed));
      req_valid = '0;
      gnt_seen  = '0;
      n_done    = 0;
      exp_data  = '0;
      exp_id    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         wait_cnt[k] = 0;
         cur_data[k] = '0;
      end
      for (int cyc = 0; cyc < 20000 && n_done < 1000; cyc++) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_seen[k]) begin
               req_valid[k] = 1'b0;
               gnt_seen[k]  = 1'b0;
            end
            if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
               cur_data[k] = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : WIDTH'($urandom);
               set_data(k, cur_data[k]);
               req_valid[k] = 1'b1;
               wait_cnt[k]  = 0;
            end
         end
         rsp_ready = 1'($urandom_range(0, 1));
         #1;
         if (req_ready != '0) begin
            check("rnd_onehot", 32'($onehot(req_ready)), 1);
            g = 0;
            for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) g = k;
            check("rnd_ready_valid", 32'(req_valid[g]), 1);
            exp_data = cur_data[g] + 20'd1;
            exp_id   = ID_W'(g);
            gnt_seen[g] = 1'b1;
            wait_cnt[g] = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
               if (k != g && req_valid[k]) begin
                  wait_cnt[k]++;
                  check("rnd_starve", 32'(wait_cnt[k] < NUM_REQ), 1);
               end
            end
         end
         if (rsp_valid && rsp_ready) begin
            check("rnd_rsp_id", 32'(rsp_id), 32'(exp_id));
            check("rnd_rsp_data", 32'(rsp_data), 32'(exp_data));
            check("rnd_rsp_wrap", 32'(rsp_wrap), 32'(exp_data == '0));
            n_done++;
         end
         step();
      end
      check("rnd_completed", 32'(n_done), 1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
